instr_fetch_decode: RTL and testbench
=====================================

// Module: instr_fetch_decode
// PURPOSE
//  Consumer side of the next-PC loop: reads instruction memory at the word index
//  driven by the next-PC unit, registers the instruction and decodes the control-flow
//  fields (branch, jumpp, SignExtImm, jumpAdress) that the next-PC unit samples.
//  Fetch is on posedge clk2; the next-PC unit updates the index on negedge clk2.
//  Also tracks retired-instruction count and a sticky halt at program end.
// PARAMETERS
//  IMEM_AW    5    instruction-memory word-address width (imem_addr = index_in[IMEM_AW-1:0])
//  MAX_INDEX  20   last valid instruction index; index_in > MAX_INDEX ends the program
// PORTS
//  clk2         in   1   system clock; fetch/state on posedge
//  rst_n        in   1   asynchronous, active-low reset
//  index_in     in   32  word index from next-PC unit (32'hFFFF_FFFF = none yet)
//  imem_rdata   in   32  instruction word, combinational read of imem_addr
//  rs_data      in   32  register-file read of rs field (combinational)
//  rt_data      in   32  register-file read of rt field (combinational)
//  imem_addr    out  IMEM_AW  instruction-memory word address
//  instr        out  32  registered instruction
//  instr_valid  out  1   instr holds a real fetched instruction
//  rs, rt, rd   out  5 each  instr[25:21], [20:16], [15:11]
//  branch       out  1   taken conditional branch (beq/bne)
//  jumpp        out  1   unconditional jump (j)
//  SignExtImm   out  32  {{16{instr[15]}}, instr[15:0]}
//  jumpAdress   out  26  instr[25:0]
//  retired      out  32  count of valid instructions fetched
//  halt         out  1   sticky end-of-program flag
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=S_RESET, instr=32'h0 (NOP), instr_valid=0,
//    retired=0, halt=0; hence branch=0, jumpp=0, SignExtImm=0, jumpAdress=0.
//  - States: S_RESET, S_RUN, S_HALT.
//    S_RESET -> S_RUN on first posedge after release; nothing captured that edge.
//    S_RUN, posedge: if index_in==32'hFFFF_FFFF: instr=0, instr_valid=0, stay.
//      else if index_in > MAX_INDEX (unsigned): state=S_HALT, halt=1, instr=0,
//      instr_valid=0.
//      else instr=imem_rdata, instr_valid=1, retired=retired+1 (wraps at 2^32).
//    S_HALT: absorbing until reset; instr=0, instr_valid=0, retired frozen.
//  - imem_addr = index_in[IMEM_AW-1:0], combinational; latency index->instr = 1 posedge.
//  - Decode from registered instr (combinational), gated by instr_valid:
//    opcode=instr[31:26]; 6'h04 beq: branch = (rs_data==rt_data);
//    6'h05 bne: branch = (rs_data!=rt_data); 6'h02 j: jumpp=1; all else 0.
//    branch and jumpp are never both 1. SignExtImm/jumpAdress driven whenever
//    instr_valid, else 0.
//  - Outputs stable from posedge through the following negedge, where the next-PC
//    unit samples them; rs_data/rt_data must settle within the high phase.
//  - Reset mid-run: immediate return to reset values; next-PC unit is reset in
//    parallel, so the -1 sentinel reappears and is handled as above.
// TESTING
//  1 Reset then index_in=FFFF_FFFF for 2 posedges -> instr_valid=0, branch=jumpp=0, retired=0.
//  2 index_in=3, imem_rdata=32'h1085_0003 (beq $4,$5,+3), rs_data=rt_data=7 ->
//    after posedge branch=1, SignExtImm=3, retired=1; rt_data=8 -> branch=0.
//  3 imem_rdata=32'h1485_FFFE (bne, imm=-2), rs_data=1, rt_data=2 -> branch=1,
//    SignExtImm=32'hFFFF_FFFE.
//  4 imem_rdata=32'h0800_000A (j 10) -> jumpp=1, branch=0, jumpAdress=26'h00000A.
//  5 index_in=21 at posedge -> halt=1, instr_valid=0; later index_in=2 -> stays halted,
//    retired unchanged.
//  6 Assert rst_n=0 between posedges while branch=1 -> branch=0, halt=0, retired=0
//    immediately, without a clock edge.

Source files
------------

// File: rtl/instr_fetch_decode.sv
// Instruction fetch/decode stage feeding the next-PC unit: registers the word at index_in
// and decodes branch/jump controls; counts retired fetches and raises a sticky halt.
module instr_fetch_decode #(
    parameter int unsigned IMEM_AW   = 5,
    parameter int unsigned MAX_INDEX = 20
) (
    input  logic               clk2,
    input  logic               rst_n,
    input  logic [31:0]        index_in,
    input  logic [31:0]        imem_rdata,
    input  logic [31:0]        rs_data,
    input  logic [31:0]        rt_data,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [31:0]        instr,
    output logic               instr_valid,
    output logic [4:0]         rs,
    output logic [4:0]         rt,
    output logic [4:0]         rd,
    output logic               branch,
    output logic               jumpp,
    output logic [31:0]        SignExtImm,
    output logic [25:0]        jumpAdress,
    output logic [31:0]        retired,
    output logic               halt
);

    typedef enum logic [1:0] {StReset, StRun, StHalt} state_e;

    localparam logic [31:0] IndexNone = 32'hFFFF_FFFF;
    localparam logic [5:0]  OpBeq     = 6'h04;
    localparam logic [5:0]  OpBne     = 6'h05;
    localparam logic [5:0]  OpJ       = 6'h02;

    state_e      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic [31:0] retired_q, retired_d;
    logic        halt_q, halt_d;

    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StReset;
            instr_q   <= 32'h0;
            valid_q   <= 1'b0;
            retired_q <= 32'h0;
            halt_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            retired_q <= retired_d;
            halt_q    <= halt_d;
        end
    end

    // Anything other than a real fetch leaves a NOP in the instruction register.
    always_comb begin
        state_d   = state_q;
        instr_d   = 32'h0;
        valid_d   = 1'b0;
        retired_d = retired_q;
        halt_d    = halt_q;
        case (state_q)
            StReset: state_d = StRun;
            StRun: begin
                if (index_in == IndexNone) begin
                    state_d = StRun;
                end else if (index_in > MAX_INDEX) begin
                    state_d = StHalt;
                    halt_d  = 1'b1;
                end else begin
                    instr_d   = imem_rdata;
                    valid_d   = 1'b1;
                    retired_d = retired_q + 32'd1;
                end
            end
            StHalt:  state_d = StHalt;
            default: state_d = StReset;
        endcase
    end

    assign imem_addr   = index_in[IMEM_AW-1:0];
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign retired     = retired_q;
    assign halt        = halt_q;
    assign rs          = instr_q[25:21];
    assign rt          = instr_q[20:16];
    assign rd          = instr_q[15:11];

    always_comb begin
        branch     = 1'b0;
        jumpp      = 1'b0;
        SignExtImm = 32'h0;
        jumpAdress = 26'h0;
        if (valid_q) begin
            SignExtImm = {{16{instr_q[15]}}, instr_q[15:0]};
            jumpAdress = instr_q[25:0];
            case (instr_q[31:26])
                OpBeq:   branch = (rs_data == rt_data);
                OpBne:   branch = (rs_data != rt_data);
                OpJ:     jumpp  = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Scoreboard bench for instr_fetch_decode: stimulus queues expected outputs, a monitor
// compares them at the following negedge (or immediately for async-reset probes).
module tb_instr_fetch_decode;

    logic        clk2 = 1'b0;
    logic        rst_n;
    logic [31:0] index_in, imem_rdata, rs_data, rt_data;
    logic [4:0]  imem_addr;
    logic [31:0] instr, SignExtImm, retired;
    logic        instr_valid, branch, jumpp, halt;
    logic [4:0]  rs, rt, rd;
    logic [25:0] jumpAdress;

    instr_fetch_decode #(.IMEM_AW(5), .MAX_INDEX(20)) dut (
        .clk2        (clk2),
        .rst_n       (rst_n),
        .index_in    (index_in),
        .imem_rdata  (imem_rdata),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .imem_addr   (imem_addr),
        .instr       (instr),
        .instr_valid (instr_valid),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .branch      (branch),
        .jumpp       (jumpp),
        .SignExtImm  (SignExtImm),
        .jumpAdress  (jumpAdress),
        .retired     (retired),
        .halt        (halt)
    );

    always #5 clk2 = ~clk2;

    typedef struct {
        string       name;
        logic [31:0] ins;
        logic        v;
        logic        br;
        logic        jp;
        logic [31:0] sext;
        logic [25:0] ja;
        logic [31:0] ret;
        logic        h;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    event probe;

    function automatic exp_t mk(input string nm, input logic [31:0] ins, input logic v,
                                input logic br, input logic jp, input logic [31:0] sext,
                                input logic [25:0] ja, input logic [31:0] ret, input logic h);
        exp_t e;
        e.name = nm; e.ins = ins; e.v = v; e.br = br; e.jp = jp;
        e.sext = sext; e.ja = ja; e.ret = ret; e.h = h;
        return e;
    endfunction

    task automatic chk(input string nm, input string fld, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, req);
        end
    endtask

    // Monitor: pop one expectation per negedge (or per async probe) and compare.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk2 or probe);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk(e.name, "instr", instr, e.ins);
                chk(e.name, "instr_valid", 32'(instr_valid), 32'(e.v));
                chk(e.name, "branch", 32'(branch), 32'(e.br));
                chk(e.name, "jumpp", 32'(jumpp), 32'(e.jp));
                chk(e.name, "SignExtImm", SignExtImm, e.sext);
                chk(e.name, "jumpAdress", 32'(jumpAdress), 32'(e.ja));
                chk(e.name, "retired", retired, e.ret);
                chk(e.name, "halt", 32'(halt), 32'(e.h));
                chk(e.name, "imem_addr", 32'(imem_addr), 32'(index_in[4:0]));
            end
        end
    end

    // Drive inputs just after a negedge; expectation is checked at the next negedge.
    task automatic step(input logic [31:0] idx, input logic [31:0] rdata,
                        input logic [31:0] rsd, input logic [31:0] rtd, input exp_t e);
        @(negedge clk2);
        #1;
        index_in = idx; imem_rdata = rdata; rs_data = rsd; rt_data = rtd;
        q.push_back(e);
    endtask

    task automatic probe_reset(input string nm);
        #1;
        q.push_back(mk(nm, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 26'h0, 32'h0, 1'b0));
        ->probe;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        index_in = 32'hFFFF_FFFF; imem_rdata = 32'h0; rs_data = 32'h0; rt_data = 32'h0;
        probe_reset("reset_init");
        #10 rst_n = 1'b1;

        // Sentinel index: nothing fetched.
        step(32'hFFFF_FFFF, 32'h1085_0003, 32'd7, 32'd7,
             mk("none0", 32'h0, 0, 0, 0, 32'h0, 26'h0, 32'd0, 0));
        step(32'hFFFF_FFFF, 32'h1085_0003, 32'd7, 32'd7,
             mk("none1", 32'h0, 0, 0, 0, 32'h0, 26'h0, 32'd0, 0));
        // beq taken / not taken.
        step(32'd3, 32'h1085_0003, 32'd7, 32'd7,
             mk("beq_t", 32'h1085_0003, 1, 1, 0, 32'h3, 26'h085_0003, 32'd1, 0));
        step(32'd3, 32'h1085_0003, 32'd7, 32'd8,
             mk("beq_nt", 32'h1085_0003, 1, 0, 0, 32'h3, 26'h085_0003, 32'd2, 0));
        // bne taken / not taken, negative immediate.
        step(32'd4, 32'h1485_FFFE, 32'd1, 32'd2,
             mk("bne_t", 32'h1485_FFFE, 1, 1, 0, 32'hFFFF_FFFE, 26'h085_FFFE, 32'd3, 0));
        step(32'd4, 32'h1485_FFFE, 32'd2, 32'd2,
             mk("bne_nt", 32'h1485_FFFE, 1, 0, 0, 32'hFFFF_FFFE, 26'h085_FFFE, 32'd4, 0));
        // j: never a branch even with equal operands.
        step(32'd5, 32'h0800_000A, 32'd9, 32'd9,
             mk("j", 32'h0800_000A, 1, 0, 1, 32'h0000_000A, 26'h000_000A, 32'd5, 0));
        // Non-control opcode.
        step(32'd6, 32'h2000_0005, 32'd9, 32'd9,
             mk("addi", 32'h2000_0005, 1, 0, 0, 32'h0000_0005, 26'h000_0005, 32'd6, 0));
        // Last valid index is still fetched.
        step(32'd20, 32'h1000_FFFF, 32'd3, 32'd3,
             mk("max_idx", 32'h1000_FFFF, 1, 1, 0, 32'hFFFF_FFFF, 26'h000_FFFF, 32'd7, 0));
        step(32'hFFFF_FFFF, 32'h1085_0003, 32'd7, 32'd7,
             mk("none_mid", 32'h0, 0, 0, 0, 32'h0, 26'h0, 32'd7, 0));
        // Past the end: sticky halt.
        step(32'd21, 32'h1085_0003, 32'd7, 32'd7,
             mk("halt", 32'h0, 0, 0, 0, 32'h0, 26'h0, 32'd7, 1));
        step(32'd2, 32'h1085_0003, 32'd7, 32'd7,
             mk("halt_hold0", 32'h0, 0, 0, 0, 32'h0, 26'h0, 32'd7, 1));
        step(32'd2, 32'h0800_000A, 32'd7, 32'd7,
             mk("halt_hold1", 32'h0, 0, 0, 0, 32'h0, 26'h0, 32'd7, 1));

        // Reset out of halt.
        @(negedge clk2);
        #1 rst_n = 1'b0;
        probe_reset("reset_halt");
        rst_n = 1'b1;
        step(32'hFFFF_FFFF, 32'h1085_0003, 32'd7, 32'd7,
             mk("post_rst_none", 32'h0, 0, 0, 0, 32'h0, 26'h0, 32'd0, 0));
        step(32'd3, 32'h1085_0003, 32'd7, 32'd7,
             mk("post_rst_beq", 32'h1085_0003, 1, 1, 0, 32'h3, 26'h085_0003, 32'd1, 0));

        // Async reset in the high phase while branch is asserted.
        @(negedge clk2);
        @(posedge clk2);
        #2 rst_n = 1'b0;
        probe_reset("reset_async");
        @(negedge clk2);
        #2 rst_n = 1'b1;
        step(32'd5, 32'h0800_000A, 32'd1, 32'd1,
             mk("resume_j", 32'h0800_000A, 1, 0, 1, 32'h0000_000A, 26'h000_000A, 32'd1, 0));

        @(negedge clk2);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
